// File: rtl/seq_div.sv
// ---------------------------------------------------------------------------
// seq_div -- sequential unsigned restoring divider, radix-2.
//
// Produces one quotient bit per clock: an accepted start takes N cycles of
// CALC, and results land on the completing edge together with a one-cycle
// done pulse. Divide-by-zero is answered directly from IDLE on the start
// edge. The start/busy handshake matches the team's sequential multiplier.
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous, active-low reset
//   start        request a divide; sampled only while idle
//   dividend     numerator (unsigned, N bits), sampled on the start edge
//   divisor      denominator (unsigned, N bits), sampled on the start edge
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   busy         high while a division is in progress (N cycles)
//   done         one-cycle pulse when quotient/remainder update
//   div_by_zero  status of the last completed operation
// ---------------------------------------------------------------------------
module seq_div #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  wq_q, wq_d;      // work quotient: dividend bits shift out, quotient bits shift in
  logic [N-1:0]  wr_q, wr_d;      // work (partial) remainder
  logic [N-1:0]  dvs_q, dvs_d;    // divisor captured at start
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // One restoring step. The trial subtraction is taken on the full shifted
  // partial remainder (N+1 bits) so the borrow in bit N is the sign.
  logic [N:0]    trial;
  logic [N-1:0]  shr;
  logic [N-1:0]  step_wr;
  logic [N-1:0]  step_wq;

  assign trial   = {wr_q, wq_q[N-1]} - {1'b0, dvs_q};
  assign shr     = {wr_q[N-2:0], wq_q[N-1]};
  assign step_wr = trial[N] ? shr : trial[N-1:0];
  assign step_wq = {wq_q[N-2:0], ~trial[N]};

  always_comb begin
    state_d = state_q;
    wq_d    = wq_q;
    wr_d    = wr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            wq_d    = dividend;
            wr_d    = '0;
            dvs_d   = divisor;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            // Divide-by-zero completes immediately without entering CALC.
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end

      CALC: begin
        wq_d  = step_wq;
        wr_d  = step_wr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          quot_d  = step_wq;
          rem_d   = step_wr;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wq_q    <= '0;
      wr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wq_q    <= wq_d;
      wr_q    <= wr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// ---------------------------------------------------------------------------
// tb_seq_div -- self-checking bench for seq_div (N=16).
// Expected results come from plain integer division in the bench.
// ---------------------------------------------------------------------------
module tb_seq_div;

  localparam int N   = 16;
  localparam int LIM = 100;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_total;
  int n_bad;

  seq_div #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic, with the divide-by-zero convention.
  function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issue one start pulse and wait (bounded) for done. lat counts edges
  // after the start edge until done is seen; bcnt counts cycles busy was high.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic z, output int lat, output int bcnt);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < LIM) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    n_total++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    n_total++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] q, r; logic z; int lat, bc;
    run_div(16'd100, 16'd7, q, r, z, lat, bc);
    n_total++;
    if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want 14 2 0", q, r, z);
    end
    n_total++;
    if (lat !== N || bc !== N) begin
      n_bad++;
      $display("FAIL basic_latency: got lat=%0d busy_cycles=%0d, want %0d %0d", lat, bc, N, N);
    end
    tick();
    n_total++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: got done=%b, want 0", done);
    end
    repeat (3) tick();
    n_total++;
    if ({quotient, remainder} !== {16'd14, 16'd2}) begin
      n_bad++;
      $display("FAIL basic_hold: got q=%0d r=%0d, want 14 2", quotient, remainder);
    end
  endtask

  task automatic test_edges();
    logic [N-1:0] a_t [4] = '{16'hFFFF, 16'd5, 16'd0, 16'hFFFF};
    logic [N-1:0] b_t [4] = '{16'd1,    16'd9, 16'd3, 16'hFFFF};
    logic [N-1:0] q, r, eq, er; logic z, ez; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_div(a_t[i], b_t[i], q, r, z, lat, bc);
      ref_div(a_t[i], b_t[i], eq, er, ez);
      n_total++;
      if ({q, r, z} !== {eq, er, ez} || lat !== N) begin
        n_bad++;
        $display("FAIL edge_%0d (%h/%h): got q=%h r=%h dbz=%b lat=%0d, want %h %h %b %0d",
                 i, a_t[i], b_t[i], q, r, z, lat, eq, er, ez, N);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] q, r; logic z; int lat, bc;
    run_div(16'd1234, 16'd0, q, r, z, lat, bc);
    n_total++;
    if ({q, r, z} !== {16'hFFFF, 16'd1234, 1'b1}) begin
      n_bad++;
      $display("FAIL div0_result: got q=%h r=%0d dbz=%b, want ffff 1234 1", q, r, z);
    end
    n_total++;
    if (lat !== 0 || bc !== 0) begin
      n_bad++;
      $display("FAIL div0_timing: got lat=%0d busy_cycles=%0d, want 0 0", lat, bc);
    end
    run_div(16'd9, 16'd3, q, r, z, lat, bc);
    n_total++;
    if ({q, r, z} !== {16'd3, 16'd0, 1'b0} || lat !== N) begin
      n_bad++;
      $display("FAIL after_div0: got q=%0d r=%0d dbz=%b lat=%0d, want 3 0 0 %0d", q, r, z, lat, N);
    end
  endtask

  task automatic test_back_to_back();
    int k, k1, k2, dones;
    logic [N-1:0] q1, r1, q2, r2, ql, rl;
    k1 = -1; k2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    tick();
    k = 0;
    // Operand change while busy, start kept high throughout.
    while (k2 < 0 && k < 3 * LIM) begin
      if (k == 3) dividend = 16'd7;
      tick();
      k++;
      if (done) begin
        if (k1 < 0) begin k1 = k; q1 = quotient; r1 = remainder; end
        else begin k2 = k; q2 = quotient; r2 = remainder; start = 1'b0; end
      end
    end
    start = 1'b0;
    n_total++;
    if ({q1, r1} !== {16'd100, 16'd0} || k1 !== N) begin
      n_bad++;
      $display("FAIL captured_operands: got q=%0d r=%0d at %0d, want 100 0 at %0d", q1, r1, k1, N);
    end
    n_total++;
    if (k2 - k1 !== N + 1 || {q2, r2} !== {16'd0, 16'd7}) begin
      n_bad++;
      $display("FAIL back_to_back: got gap=%0d q=%0d r=%0d, want %0d 0 7", k2 - k1, q2, r2, N + 1);
    end
    // A start pulse while busy must be ignored.
    tick();
    start = 1'b1; dividend = 16'd20; divisor = 16'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; dividend = 16'd99; divisor = 16'd2;
    tick();
    start = 1'b0;
    dones = 0; ql = '0; rl = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin dones++; ql = quotient; rl = remainder; end
      tick();
    end
    n_total++;
    if (dones !== 1 || {ql, rl} !== {16'd5, 16'd0}) begin
      n_bad++;
      $display("FAIL start_while_busy: got dones=%0d q=%0d r=%0d, want 1 5 0", dones, ql, rl);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] q, r; logic z; int lat, bc, dones;
    start = 1'b1; dividend = 16'd500; divisor = 16'd3;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dones++;
      tick();
    end
    n_total++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abandoned_op: got %0d active cycles after reset, want 0", dones);
    end
    run_div(16'd500, 16'd3, q, r, z, lat, bc);
    n_total++;
    if ({q, r, z} !== {16'd166, 16'd2, 1'b0} || lat !== N) begin
      n_bad++;
      $display("FAIL after_reset_mid: got q=%0d r=%0d dbz=%b lat=%0d, want 166 2 0 %0d", q, r, z, lat, N);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, r, eq, er; logic z, ez; int lat, bc;
    for (int i = 0; i < 3500; i++) begin
      if (i < 1500) begin
        a = N'($urandom_range(0, 255));
        b = N'($urandom_range(1, 255));
      end else begin
        a = N'($urandom);
        b = (i % 97 == 0) ? '0 : N'($urandom);
        if (i % 5 == 0) b = b >> $urandom_range(0, 15);
      end
      run_div(a, b, q, r, z, lat, bc);
      ref_div(a, b, eq, er, ez);
      n_total++;
      if ({q, r, z} !== {eq, er, ez} || lat !== ((b == 0) ? 0 : N)) begin
        n_bad++;
        $display("FAIL random_%0d (%h/%h): got q=%h r=%h dbz=%b lat=%0d, want %h %h %b",
                 i, a, b, q, r, z, lat, eq, er, ez);
      end
      if (b != 0) begin
        n_total++;
        if (32'(q) * 32'(b) + 32'(r) != 32'(a) || r >= b) begin
          n_bad++;
          $display("FAIL invariant_%0d (%h/%h): got q=%h r=%h, want q*b+r=a and r<b", i, a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
